heading_odometry_controller: RTL and testbench

- Sequences the per-sample heading update for the Cyclone Cruiser odometry path.
- On each `start` it latches the right and left wheel distance increments and computes delta_theta = (dR − dL)·1000 / wheel base in milliradians, using a shared bit-serial divider.
- It accumulates delta_theta into a wrapped absolute heading and reports completion with a one-cycle `done` pulse.
- It sits between the encoder distance counters and the pose/navigation logic, and replaces the purely combinational real-valued divide with a synthesizable integer sequence.

---
 rtl/heading_odometry_controller_if.sv | 29 ++
 rtl/heading_odometry_controller.sv | 155 +++++++++++++++
 tb/tb_heading_odometry_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/heading_odometry_controller_if.sv
// Request/result bundle between the odometry heading sequencer and its user.
// The state_dbg signal mirrors the sequencer's FSM state for observation.
`timescale 1ns/1ps

interface heading_odometry_controller_if;
   // Handshake: start is taken only while busy is low (a start seen while busy
   // is dropped, not queued); done pulses for one cycle when delta_theta and
   // heading hold the new result. Distances need only be valid in the start cycle.
   logic               start;
   logic signed [31:0] distance_right;
   logic signed [31:0] distance_left;
   logic               clear_heading;
   logic               busy;
   logic               done;
   logic signed [31:0] delta_theta;
   logic signed [31:0] heading;
   logic               sat;
   logic [2:0]         state_dbg;

   modport master (
      output start, distance_right, distance_left, clear_heading,
      input  busy, done, delta_theta, heading, sat, state_dbg
   );

   modport slave (
      input  start, distance_right, distance_left, clear_heading,
      output busy, done, delta_theta, heading, sat, state_dbg
   );
endinterface

// File: rtl/heading_odometry_controller.sv
// Per-sample heading update: delta_theta = (dR - dL) * 1000 / wheel base [mrad],
// computed with a bit-serial restoring divider and accumulated into a wrapped heading.
`timescale 1ns/1ps

module heading_odometry_controller #(
   parameter int WHEEL_BASE_MM = 100,
   parameter int TWO_PI_MRAD   = 6283,
   parameter int HALF_PI_RANGE = 3141
) (
   input logic                          clock,
   input logic                          reset,
   heading_odometry_controller_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DIV   = 3'd2,
      S_FIX   = 3'd3,
      S_ACCUM = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic        [42:0] DIVISOR   = 43'(WHEEL_BASE_MM);
   localparam logic signed [43:0] HALF_Q    = 44'(HALF_PI_RANGE);
   localparam logic signed [31:0] HALF_D    = 32'(HALF_PI_RANGE);
   localparam logic signed [32:0] HALF_S    = 33'(HALF_PI_RANGE);
   localparam logic signed [32:0] TWO_S     = 33'(TWO_PI_MRAD);
   localparam logic        [5:0]  LAST_STEP = 6'd42;

   if (WHEEL_BASE_MM <= 0) begin : g_bad_wheel_base
      $error("heading_odometry_controller: WHEEL_BASE_MM must be > 0");
   end

   state_t             state_q, state_d;
   logic signed [31:0] dr_q, dl_q;
   logic               neg_q;
   logic        [42:0] quo_q, rem_q;
   logic        [5:0]  cnt_q;
   logic signed [31:0] delta_q, heading_q;
   logic               sat_q;

   logic signed [32:0] diff;
   logic signed [42:0] num;
   logic        [42:0] mag;
   logic        [42:0] trial, rem_step, quo_step;
   logic               ge;
   logic signed [43:0] q_signed;
   logic signed [31:0] q_clamped;
   logic               q_sat;
   logic signed [32:0] base, sum, wrapped_full;
   logic signed [31:0] wrapped;

   // Datapath: |(dR-dL)*1000| < 2^42, so 43-bit signed never overflows.
   always_comb begin
      diff     = 33'(dr_q) - 33'(dl_q);
      num      = 43'(diff) * 43'sd1000;
      mag      = num[42] ? $unsigned(-num) : $unsigned(num);

      trial    = {rem_q[41:0], quo_q[42]};
      ge       = (trial >= DIVISOR);
      rem_step = ge ? (trial - DIVISOR) : trial;
      quo_step = {quo_q[41:0], ge};

      q_signed = neg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
      q_clamped = q_signed[31:0];
      q_sat     = 1'b0;
      if (q_signed > HALF_Q) begin
         q_clamped = HALF_D;
         q_sat     = 1'b1;
      end else if (q_signed < -HALF_Q) begin
         q_clamped = -HALF_D;
         q_sat     = 1'b1;
      end

      // |delta| <= HALF_PI_RANGE, so one wrap correction always suffices.
      base = bus.clear_heading ? 33'sd0 : 33'(heading_q);
      sum  = base + 33'(delta_q);
      wrapped_full = sum;
      if (sum > HALF_S) begin
         wrapped_full = sum - TWO_S;
      end else if (sum < -HALF_S) begin
         wrapped_full = sum + TWO_S;
      end
      wrapped = wrapped_full[31:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_LOAD;
         S_LOAD:  state_d = S_DIV;
         S_DIV:   if (cnt_q == LAST_STEP) state_d = S_FIX;
         S_FIX:   state_d = S_ACCUM;
         S_ACCUM: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         dr_q      <= '0;
         dl_q      <= '0;
         neg_q     <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         delta_q   <= '0;
         heading_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  dr_q <= bus.distance_right;
                  dl_q <= bus.distance_left;
               end
            end
            S_LOAD: begin
               neg_q <= num[42];
               quo_q <= mag;
               rem_q <= '0;
               cnt_q <= '0;
            end
            S_DIV: begin
               quo_q <= quo_step;
               rem_q <= rem_step;
               cnt_q <= cnt_q + 6'd1;
            end
            S_FIX: begin
               delta_q <= q_clamped;
               sat_q   <= q_sat;
            end
            default: ;
         endcase
         // In ACCUM clear_heading acts through base; elsewhere it zeroes directly.
         if (state_q == S_ACCUM) begin
            heading_q <= wrapped;
         end else if (bus.clear_heading) begin
            heading_q <= '0;
         end
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.delta_theta = delta_q;
   assign bus.heading     = heading_q;
   assign bus.sat         = sat_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_heading_odometry_controller.sv
// Directed bench for heading_odometry_controller: latency, busy window, wrap,
// saturation, truncation (second instance, 300 mm base), clear and mid-run reset.
`timescale 1ns/1ps

module tb_heading_odometry_controller;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   heading_odometry_controller_if bus1 ();
   heading_odometry_controller_if bus2 ();

   heading_odometry_controller #(.WHEEL_BASE_MM(100)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1.slave)
   );

   heading_odometry_controller #(.WHEEL_BASE_MM(300)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2.slave)
   );

   task automatic drive_start(input bit sel, input logic v);
      if (sel) bus2.start = v;
      else     bus1.start = v;
   endtask

   task automatic drive_clear(input bit sel, input logic v);
      if (sel) bus2.clear_heading = v;
      else     bus1.clear_heading = v;
   endtask

   // One update: start sampled at edge t; observe cycles n = 1..60 at negedges.
   task automatic run_op(input bit sel, input logic signed [31:0] dr,
                         input logic signed [31:0] dl, input int clr_at,
                         input int restart_at, output int done_cyc,
                         output int done_cnt, output int busy_err);
      logic d, b;
      @(negedge clock);
      if (sel) begin
         bus2.distance_right = dr;
         bus2.distance_left  = dl;
      end else begin
         bus1.distance_right = dr;
         bus1.distance_left  = dl;
      end
      drive_start(sel, 1'b1);
      done_cyc = -1;
      done_cnt = 0;
      busy_err = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clock);
         if (n == 1 || n == restart_at + 1) drive_start(sel, 1'b0);
         if (n == restart_at) drive_start(sel, 1'b1);
         if (n == clr_at) drive_clear(sel, 1'b1);
         if (n == clr_at + 1) drive_clear(sel, 1'b0);
         d = sel ? bus2.done : bus1.done;
         b = sel ? bus2.busy : bus1.busy;
         if (d) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (b !== (n <= 47)) busy_err++;
      end
   endtask

   task automatic clear_idle(input bit sel);
      @(negedge clock);
      drive_clear(sel, 1'b1);
      @(negedge clock);
      drive_clear(sel, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus1.start = 0; bus1.clear_heading = 0; bus1.distance_right = 0; bus1.distance_left = 0;
      bus2.start = 0; bus2.clear_heading = 0; bus2.distance_right = 0; bus2.distance_left = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
      total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus1.done); end
      total++; if (bus1.sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", bus1.sat); end
      total++; if (bus1.delta_theta !== 32'sd0) begin bad++; $display("FAIL reset_delta: got %0d want 0", bus1.delta_theta); end
      total++; if (bus1.heading !== 32'sd0) begin bad++; $display("FAIL reset_heading: got %0d want 0", bus1.heading); end
      total++; if (bus1.state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus1.state_dbg); end
      total++; if (bus2.heading !== 32'sd0) begin bad++; $display("FAIL reset_heading2: got %0d want 0", bus2.heading); end
   endtask

   task automatic test_basic();
      int dc, cnt, be;
      run_op(1'b0, 32'sd50, 32'sd30, 0, 0, dc, cnt, be);
      total++; if (dc !== 47) begin bad++; $display("FAIL basic_latency: got %0d want 47", dc); end
      total++; if (cnt !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", cnt); end
      total++; if (be !== 0) begin bad++; $display("FAIL basic_busy_window: got %0d errors want 0", be); end
      total++; if (bus1.delta_theta !== 32'sd200) begin bad++; $display("FAIL basic_delta: got %0d want 200", bus1.delta_theta); end
      total++; if (bus1.heading !== 32'sd200) begin bad++; $display("FAIL basic_heading: got %0d want 200", bus1.heading); end
      total++; if (bus1.sat !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", bus1.sat); end
   endtask

   task automatic test_ignore_start();
      int dc, cnt, be;
      run_op(1'b0, 32'sd0, 32'sd7, 0, 5, dc, cnt, be);
      total++; if (cnt !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", cnt); end
      total++; if (dc !== 47) begin bad++; $display("FAIL ignore_latency: got %0d want 47", dc); end
      total++; if (be !== 0) begin bad++; $display("FAIL ignore_busy_window: got %0d errors want 0", be); end
      total++; if (bus1.delta_theta !== -32'sd70) begin bad++; $display("FAIL ignore_delta: got %0d want -70", bus1.delta_theta); end
      total++; if (bus1.heading !== 32'sd130) begin bad++; $display("FAIL ignore_heading: got %0d want 130", bus1.heading); end
   endtask

   task automatic test_wrap();
      int dc, cnt, be;
      clear_idle(1'b0);
      for (int i = 0; i < 15; i++) run_op(1'b0, 32'sd20, 32'sd0, 0, 0, dc, cnt, be);
      total++; if (bus1.heading !== 32'sd3000) begin bad++; $display("FAIL wrap_pos_pre: got %0d want 3000", bus1.heading); end
      run_op(1'b0, 32'sd20, 32'sd0, 0, 0, dc, cnt, be);
      total++; if (bus1.delta_theta !== 32'sd200) begin bad++; $display("FAIL wrap_pos_delta: got %0d want 200", bus1.delta_theta); end
      total++; if (bus1.heading !== -32'sd3083) begin bad++; $display("FAIL wrap_pos_heading: got %0d want -3083", bus1.heading); end
      clear_idle(1'b0);
      for (int i = 0; i < 15; i++) run_op(1'b0, 32'sd0, 32'sd20, 0, 0, dc, cnt, be);
      total++; if (bus1.heading !== -32'sd3000) begin bad++; $display("FAIL wrap_neg_pre: got %0d want -3000", bus1.heading); end
      run_op(1'b0, 32'sd0, 32'sd20, 0, 0, dc, cnt, be);
      total++; if (bus1.delta_theta !== -32'sd200) begin bad++; $display("FAIL wrap_neg_delta: got %0d want -200", bus1.delta_theta); end
      total++; if (bus1.heading !== 32'sd3083) begin bad++; $display("FAIL wrap_neg_heading: got %0d want 3083", bus1.heading); end
   endtask

   task automatic test_saturation();
      int dc, cnt, be;
      clear_idle(1'b0);
      run_op(1'b0, 32'sd400, 32'sd0, 0, 0, dc, cnt, be);
      total++; if (bus1.delta_theta !== 32'sd3141) begin bad++; $display("FAIL sat_pos_delta: got %0d want 3141", bus1.delta_theta); end
      total++; if (bus1.sat !== 1'b1) begin bad++; $display("FAIL sat_pos_flag: got %b want 1", bus1.sat); end
      total++; if (bus1.heading !== 32'sd3141) begin bad++; $display("FAIL sat_pos_heading: got %0d want 3141", bus1.heading); end
      run_op(1'b0, 32'sd0, 32'sd400, 0, 0, dc, cnt, be);
      total++; if (bus1.delta_theta !== -32'sd3141) begin bad++; $display("FAIL sat_neg_delta: got %0d want -3141", bus1.delta_theta); end
      total++; if (bus1.sat !== 1'b1) begin bad++; $display("FAIL sat_neg_flag: got %b want 1", bus1.sat); end
      total++; if (bus1.heading !== 32'sd0) begin bad++; $display("FAIL sat_neg_heading: got %0d want 0", bus1.heading); end
      run_op(1'b0, 32'sh7FFFFFFF, 32'sh80000000, 0, 0, dc, cnt, be);
      total++; if (bus1.delta_theta !== 32'sd3141) begin bad++; $display("FAIL extreme_delta: got %0d want 3141", bus1.delta_theta); end
      total++; if (bus1.sat !== 1'b1) begin bad++; $display("FAIL extreme_sat: got %b want 1", bus1.sat); end
      total++; if (bus1.heading !== 32'sd3141) begin bad++; $display("FAIL extreme_heading: got %0d want 3141", bus1.heading); end
      run_op(1'b0, 32'sh7FFFFFFF, 32'sh80000000, 0, 0, dc, cnt, be);
      total++; if (bus1.heading !== -32'sd1) begin bad++; $display("FAIL extreme_wrap_heading: got %0d want -1", bus1.heading); end
   endtask

   task automatic test_truncation();
      int dc, cnt, be;
      run_op(1'b1, 32'sd0, 32'sd1, 0, 0, dc, cnt, be);
      total++; if (dc !== 47) begin bad++; $display("FAIL trunc_latency: got %0d want 47", dc); end
      total++; if (bus2.delta_theta !== -32'sd3) begin bad++; $display("FAIL trunc_neg_delta: got %0d want -3", bus2.delta_theta); end
      total++; if (bus2.sat !== 1'b0) begin bad++; $display("FAIL trunc_neg_sat: got %b want 0", bus2.sat); end
      run_op(1'b1, 32'sd2, 32'sd0, 0, 0, dc, cnt, be);
      total++; if (bus2.delta_theta !== 32'sd6) begin bad++; $display("FAIL trunc_pos_delta: got %0d want 6", bus2.delta_theta); end
      total++; if (bus2.heading !== 32'sd3) begin bad++; $display("FAIL trunc_heading: got %0d want 3", bus2.heading); end
   endtask

   task automatic test_clear_heading();
      int dc, cnt, be;
      // heading is -1 here; clear in ACCUM (cycle 46) makes base 0.
      run_op(1'b0, 32'sd20, 32'sd0, 46, 0, dc, cnt, be);
      total++; if (bus1.delta_theta !== 32'sd200) begin bad++; $display("FAIL clr_accum_delta: got %0d want 200", bus1.delta_theta); end
      total++; if (bus1.heading !== 32'sd200) begin bad++; $display("FAIL clr_accum_heading: got %0d want 200", bus1.heading); end
      total++; if (bus1.sat !== 1'b0) begin bad++; $display("FAIL clr_accum_sat: got %b want 0", bus1.sat); end
      clear_idle(1'b0);
      total++; if (bus1.heading !== 32'sd0) begin bad++; $display("FAIL clr_idle_heading: got %0d want 0", bus1.heading); end
      total++; if (bus1.delta_theta !== 32'sd200) begin bad++; $display("FAIL clr_idle_delta: got %0d want 200", bus1.delta_theta); end
   endtask

   task automatic test_reset_mid();
      int dc, cnt, be, done_seen;
      run_op(1'b0, 32'sd50, 32'sd30, 0, 0, dc, cnt, be);
      @(negedge clock);
      bus1.distance_right = 32'sd0;
      bus1.distance_left  = 32'sd7;
      bus1.start = 1'b1;
      done_seen = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (n == 1) bus1.start = 1'b0;
         if (bus1.done) done_seen++;
      end
      reset = 1'b1;
      @(negedge clock);
      total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus1.busy); end
      total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", bus1.done); end
      total++; if (bus1.heading !== 32'sd0) begin bad++; $display("FAIL midrst_heading: got %0d want 0", bus1.heading); end
      total++; if (bus1.delta_theta !== 32'sd0) begin bad++; $display("FAIL midrst_delta: got %0d want 0", bus1.delta_theta); end
      total++; if (bus1.sat !== 1'b0) begin bad++; $display("FAIL midrst_sat: got %b want 0", bus1.sat); end
      reset = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (bus1.done) done_seen++;
      end
      total++; if (done_seen !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
      run_op(1'b0, 32'sd50, 32'sd30, 0, 0, dc, cnt, be);
      total++; if (dc !== 47) begin bad++; $display("FAIL midrst_fresh_latency: got %0d want 47", dc); end
      total++; if (bus1.delta_theta !== 32'sd200) begin bad++; $display("FAIL midrst_fresh_delta: got %0d want 200", bus1.delta_theta); end
      total++; if (bus1.heading !== 32'sd200) begin bad++; $display("FAIL midrst_fresh_heading: got %0d want 200", bus1.heading); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_wrap();
      test_saturation();
      test_truncation();
      test_clear_heading();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
